// File: rtl/cram_arbiter.sv
// Cartridge-RAM word-port arbiter: write-combines loader bytes, issues offset sample reads.
// Optional one-word read cache is compiled in when CRAM_ARB_READ_CACHE_EN is defined.
module cram_arbiter #(
    parameter int                ADDR_W     = 25,
    parameter int                RD_ADDR_W  = 16,
    parameter logic [ADDR_W-1:0] RD_BASE    = '0,
    parameter int                FLUSH_IDLE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [7:0]           wr_data,
    input  logic                 rd,
    input  logic [RD_ADDR_W-1:0] rd_addr,
    output logic [7:0]           rd_data,
    output logic                 rd_valid,
    output logic                 rd_busy,
    output logic [ADDR_W-2:0]    mem_addr,
    output logic [15:0]          mem_wr_data,
    output logic [1:0]           mem_be,
    output logic                 mem_wr,
    output logic                 mem_rd,
    input  logic                 mem_busy,
    input  logic [15:0]          mem_rd_data,
    input  logic                 mem_rd_valid,
    output logic [1:0]           err
);

    localparam int WA    = ADDR_W - 1;
    localparam int CNT_W = $clog2(FLUSH_IDLE + 1);

    typedef enum logic [1:0] {IDLE, WR_CMD, RD_CMD, RD_WAIT} state_t;

    function automatic logic [15:0] merge_byte(input logic [15:0] word, input logic hi,
                                               input logic [7:0] b);
        merge_byte = hi ? {b, word[7:0]} : {word[15:8], b};
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        sat_inc = (v == '1) ? v : v + 1'b1;
    endfunction

    state_t            state, state_nx;

    logic              c_vld;
    logic [WA-1:0]     c_addr;
    logic [15:0]       c_data;
    logic [1:0]        c_be;
    logic [CNT_W-1:0]  idle_cnt;

    logic              f_vld;
    logic [WA-1:0]     f_addr;
    logic [15:0]       f_data;
    logic [1:0]        f_be;

    logic [WA-1:0]     rq_word;
    logic              rq_sel;

    logic [ADDR_W-1:0] eff;
    logic [WA-1:0]     new_word, cur_word, wr_word;
    logic              wr_same, wr_diff, wr_load, wr_drop, wr_acc;
    logic              rd_take, rd_drop, rd_pend, rd_done;
    logic              blk_c, blk_f, idle_done, need_xfer, do_xfer;
    logic [15:0]       merged_data;
    logic [1:0]        merged_be, new_be;
    logic              cache_hit;
    logic [7:0]        hit_byte;

    assign eff      = RD_BASE + ADDR_W'(rd_addr);
    assign new_word = eff[ADDR_W-1:1];
    assign wr_word  = wr_addr[ADDR_W-1:1];
    assign new_be   = wr_addr[0] ? 2'b10 : 2'b01;

    assign wr_same     = wr && c_vld && (wr_word == c_addr);
    assign wr_diff     = wr && c_vld && (wr_word != c_addr);
    assign wr_load     = wr && !c_vld;
    assign merged_data = merge_byte(c_data, wr_addr[0], wr_data);
    assign merged_be   = c_be | new_be;

    assign rd_drop  = rd && rd_busy;
    assign rd_take  = rd && !rd_busy && !cache_hit;
    assign rd_pend  = rd_take || rd_busy;
    assign rd_done  = (state == RD_WAIT) && mem_rd_valid;
    assign cur_word = rd_busy ? rq_word : new_word;

    // A read may not overtake a pending write to its own word, in C or in F.
    assign blk_c = c_vld && (c_addr == cur_word);
    assign blk_f = f_vld && (f_addr == cur_word);

    assign idle_done = idle_cnt >= CNT_W'(FLUSH_IDLE - 1);
    assign need_xfer = c_vld && (wr_diff || (wr_same && merged_be == 2'b11) ||
                                 (c_be == 2'b11) || idle_done || (rd_pend && blk_c));
    assign do_xfer   = need_xfer && !f_vld;
    assign wr_drop   = wr_diff && f_vld;
    assign wr_acc    = (state == WR_CMD) && !mem_busy;

`ifdef CRAM_ARB_READ_CACHE_EN
    logic          cache_vld;
    logic [WA-1:0] cache_tag;
    logic [15:0]   cache_word;

    assign cache_hit = rd && !rd_busy && cache_vld && (cache_tag == new_word) && !blk_c && !blk_f;
    assign hit_byte  = eff[0] ? cache_word[15:8] : cache_word[7:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            cache_vld <= 1'b0;
        end else if (rd_done) begin
            cache_vld <= 1'b1;
        end else if (wr_acc && (f_addr == cache_tag)) begin
            cache_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_done) begin
            cache_tag  <= rq_word;
            cache_word <= mem_rd_data;
        end
    end
`else
    assign cache_hit = 1'b0;
    assign hit_byte  = 8'h00;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (rd_pend && !blk_c && !blk_f) state_nx = RD_CMD;
                else if (f_vld)                  state_nx = WR_CMD;
            end
            WR_CMD:  if (!mem_busy)    state_nx = IDLE;
            RD_CMD:  if (!mem_busy)    state_nx = RD_WAIT;
            RD_WAIT: if (mem_rd_valid) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign mem_wr      = (state == WR_CMD);
    assign mem_rd      = (state == RD_CMD);
    assign mem_addr    = mem_wr ? f_addr : (mem_rd ? rq_word : '0);
    assign mem_wr_data = mem_wr ? f_data : '0;
    assign mem_be      = mem_wr ? f_be : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            c_vld    <= 1'b0;
            f_vld    <= 1'b0;
            idle_cnt <= '0;
            rd_busy  <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= 8'h00;
            err      <= 2'b00;
        end else begin
            state    <= state_nx;
            rd_valid <= 1'b0;

            if (do_xfer)      c_vld <= wr_diff;
            else if (wr_load) c_vld <= 1'b1;

            if (wr && !wr_drop) idle_cnt <= '0;
            else if (c_vld)     idle_cnt <= sat_inc(idle_cnt);

            if (do_xfer)     f_vld <= 1'b1;
            else if (wr_acc) f_vld <= 1'b0;

            if (rd_done)      rd_busy <= 1'b0;
            else if (rd_take) rd_busy <= 1'b1;

            if (rd_done) begin
                rd_valid <= 1'b1;
                rd_data  <= rq_sel ? mem_rd_data[15:8] : mem_rd_data[7:0];
            end else if (cache_hit) begin
                rd_valid <= 1'b1;
                rd_data  <= hit_byte;
            end

            if (wr_drop) err[0] <= 1'b1;
            if (rd_drop) err[1] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_xfer) begin
            f_addr <= c_addr;
            f_data <= wr_same ? merged_data : c_data;
            f_be   <= wr_same ? merged_be : c_be;
        end
        if (wr_diff ? do_xfer : wr_load) begin
            c_addr <= wr_word;
            c_data <= merge_byte(16'h0000, wr_addr[0], wr_data);
            c_be   <= new_be;
        end else if (wr_same && !do_xfer) begin
            c_data <= merged_data;
            c_be   <= merged_be;
        end
        if (rd_take) begin
            rq_word <= new_word;
            rq_sel  <= eff[0];
        end
    end

endmodule

// File: tb/tb_cram_arbiter.sv
// Scoreboard bench for cram_arbiter: expected memory commands and read bytes are queued
// as stimulus is driven and compared when the DUT issues them.
module tb_cram_arbiter;

    localparam int ADDR_W     = 25;
    localparam int RD_ADDR_W  = 16;
    localparam int FLUSH_IDLE = 16;

    typedef struct packed {
        logic [ADDR_W-2:0] addr;
        logic [15:0]       data;
        logic [15:0]       mask;
        logic [1:0]        be;
    } wexp_t;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 wr;
    logic [ADDR_W-1:0]    wr_addr;
    logic [7:0]           wr_data;
    logic                 rd;
    logic [RD_ADDR_W-1:0] rd_addr;
    logic [7:0]           rd_data;
    logic                 rd_valid;
    logic                 rd_busy;
    logic [ADDR_W-2:0]    mem_addr;
    logic [15:0]          mem_wr_data;
    logic [1:0]           mem_be;
    logic                 mem_wr;
    logic                 mem_rd;
    logic                 mem_busy;
    logic [15:0]          mem_rd_data;
    logic                 mem_rd_valid;
    logic [1:0]           err;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int last_wr_cyc = -1;
    int last_rd_cyc = -1;

    wexp_t             wq[$];
    logic [ADDR_W-2:0] rcq[$];
    logic [7:0]        rdq[$];
    wexp_t             mon_w;
    logic [ADDR_W-2:0] mon_a;
    logic [7:0]        mon_d;

    cram_arbiter #(
        .ADDR_W(ADDR_W), .RD_ADDR_W(RD_ADDR_W), .RD_BASE(25'h40000), .FLUSH_IDLE(FLUSH_IDLE)
    ) dut (
        .clk(clk), .reset(reset),
        .wr(wr), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd(rd), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid), .rd_busy(rd_busy),
        .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_be(mem_be),
        .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_busy(mem_busy),
        .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_byte(input logic [ADDR_W-1:0] a, input logic [7:0] d);
        wr = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr = 1'b0;
    endtask

    task automatic push_w(input logic [ADDR_W-2:0] a, input logic [15:0] d,
                          input logic [15:0] m, input logic [1:0] be);
        wexp_t e;
        e.addr = a; e.data = d; e.mask = m; e.be = be;
        wq.push_back(e);
    endtask

    // Waits for the read command to be taken, then answers it one cycle later.
    task automatic serve_read(input logic [15:0] word);
        int k = 0;
        while (!(mem_rd && !mem_busy) && k < 50) begin
            tick();
            k++;
        end
        check("rd_cmd_seen", {31'b0, mem_rd && !mem_busy}, 1);
        tick();
        tick();
        mem_rd_data = word; mem_rd_valid = 1'b1;
        tick();
        mem_rd_valid = 1'b0;
        check("rd_valid_lat", {31'b0, rd_valid}, 1);
        check("rd_busy_fall", {31'b0, rd_busy}, 0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (mem_wr && !mem_busy) begin
                    last_wr_cyc = cyc;
                    if (wq.size() == 0) check("wr_unexpected", 1, 0);
                    else begin
                        mon_w = wq.pop_front();
                        check("wr_addr", 32'(mem_addr), 32'(mon_w.addr));
                        check("wr_data", 32'(mem_wr_data & mon_w.mask), 32'(mon_w.data & mon_w.mask));
                        check("wr_be", 32'(mem_be), 32'(mon_w.be));
                    end
                end
                if (mem_rd && !mem_busy) begin
                    last_rd_cyc = cyc;
                    if (rcq.size() == 0) check("rd_unexpected", 1, 0);
                    else begin
                        mon_a = rcq.pop_front();
                        check("rd_addr", 32'(mem_addr), 32'(mon_a));
                    end
                end
                if (rd_valid) begin
                    if (rdq.size() == 0) check("rdv_unexpected", 1, 0);
                    else begin
                        mon_d = rdq.pop_front();
                        check("rd_data", 32'(rd_data), 32'(mon_d));
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int k;
        int t0;
        reset = 1'b1; wr = 1'b0; wr_addr = '0; wr_data = '0; rd = 1'b0; rd_addr = '0;
        mem_busy = 1'b0; mem_rd_data = '0; mem_rd_valid = 1'b0;
        tick(); tick();
        reset = 1'b0;
        check("rst_outs", {rd_data, rd_valid, rd_busy, mem_wr, mem_rd, err}, 0);
        check("rst_mem", {mem_addr, mem_be}, 0);
        check("rst_wdata", 32'(mem_wr_data), 0);

        // Write combining of two bytes into one word.
        push_w(24'h80, 16'h55AA, 16'hFFFF, 2'b11);
        wr_byte(25'h100, 8'hAA);
        repeat (7) tick();
        wr_byte(25'h101, 8'h55);
        check("comb_n1", {31'b0, mem_wr}, 0);
        tick();
        check("comb_n2", {31'b0, mem_wr}, 1);
        tick();
        check("comb_n3", {31'b0, mem_wr}, 0);
        repeat (3) tick();

        // Partial word flushed by the idle timer.
        push_w(24'h101, 16'h7E00, 16'hFF00, 2'b10);
        wr_byte(25'h203, 8'h7E);
        k = 1;
        while (!mem_wr && k < 100) begin
            tick();
            k++;
        end
        check("flush_lat", k, FLUSH_IDLE + 2);
        repeat (3) tick();

        // Read offset, byte select and latency.
        rcq.push_back(24'h20001);
        rdq.push_back(8'hBE);
        rd = 1'b1; rd_addr = 16'h0003;
        tick();
        rd = 1'b0;
        check("rd_n1", {30'b0, mem_rd, rd_busy}, 3);
        serve_read(16'hBEEF);
        tick();
        check("rdv_pulse", {31'b0, rd_valid}, 0);

        // Coherency: partial C on the read's word must be written first.
        wr_byte(25'h40300, 8'h11);
        tick(); tick();
        push_w(24'h20180, 16'h0011, 16'h00FF, 2'b01);
        rcq.push_back(24'h20180);
        rdq.push_back(8'h34);
        t0 = cyc;
        rd = 1'b1; rd_addr = 16'h0300;
        tick();
        rd = 1'b0;
        serve_read(16'h1234);
        check("coh_order", {31'b0, (last_wr_cyc > t0) && (last_wr_cyc < last_rd_cyc)}, 1);
        repeat (3) tick();

        // Overflow: stalled controller, three distinct words, then a read while busy.
        mem_busy = 1'b1;
        push_w(24'h280, 16'h0001, 16'h00FF, 2'b01);
        push_w(24'h300, 16'h0002, 16'h00FF, 2'b01);
        wr_byte(25'h500, 8'h01);
        tick();
        wr_byte(25'h600, 8'h02);
        tick();
        wr_byte(25'h700, 8'h03);
        check("err_wr", 32'(err), 1);
        rcq.push_back(24'h20008);
        rdq.push_back(8'hFE);
        rd = 1'b1; rd_addr = 16'h0010;
        tick();
        check("ovf_busy", {31'b0, rd_busy}, 1);
        tick();
        rd = 1'b0;
        check("err_rd", 32'(err), 3);
        mem_busy = 1'b0;
        serve_read(16'hCAFE);
        repeat (30) tick();
        check("err_sticky", 32'(err), 3);

        // Reset while a read is in flight; the late response is ignored.
        rcq.push_back(24'h20010);
        rd = 1'b1; rd_addr = 16'h0020;
        tick();
        rd = 1'b0;
        tick();
        check("rst_inflight", {31'b0, rd_busy}, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_mid", {27'b0, rd_busy, rd_valid, mem_rd, err}, 0);
        mem_rd_data = 16'h1111; mem_rd_valid = 1'b1;
        tick();
        mem_rd_valid = 1'b0;
        check("rst_ignore", {30'b0, rd_valid, rd_busy}, 0);
        tick();
        check("rst_ignore2", {31'b0, rd_valid}, 0);

        // Fill then reread the same word.
        rcq.push_back(24'h20010);
        rdq.push_back(8'h5B);
        rd = 1'b1; rd_addr = 16'h0020;
        tick();
        rd = 1'b0;
        serve_read(16'h9A5B);
        tick();
        rdq.push_back(8'h9A);
`ifdef CRAM_ARB_READ_CACHE_EN
        rd = 1'b1; rd_addr = 16'h0021;
        tick();
        rd = 1'b0;
        check("cache_hit", {29'b0, rd_valid, mem_rd, rd_busy}, 4);
        tick();
`else
        rcq.push_back(24'h20010);
        rd = 1'b1; rd_addr = 16'h0021;
        tick();
        rd = 1'b0;
        check("reread_mem_rd", {31'b0, mem_rd}, 1);
        serve_read(16'h9A5B);
`endif
        tick();

        // A write to the cached word forces the next read back to memory.
        push_w(24'h20010, 16'hD2C1, 16'hFFFF, 2'b11);
        wr_byte(25'h40020, 8'hC1);
        wr_byte(25'h40021, 8'hD2);
        repeat (4) tick();
        rcq.push_back(24'h20010);
        rdq.push_back(8'hD2);
        rd = 1'b1; rd_addr = 16'h0021;
        tick();
        rd = 1'b0;
        check("inval_mem_rd", {31'b0, mem_rd}, 1);
        serve_read(16'hD2C1);
        repeat (4) tick();

        check("wq_left", wq.size(), 0);
        check("rcq_left", rcq.size(), 0);
        check("rdq_left", rdq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
